jtframe_prog_fifo: RTL and testbench

Write buffer between the download formatter and the SDRAM controller's programming port. It accepts byte-lane writes (address, 16-bit data, active-low mask), merges complementary byte pairs to the same word into one full-word write, and queues them in a small FIFO. Writes are replayed to the SDRAM with a request/acknowledge handshake, so bursty download traffic never stalls on SDRAM refresh or bank latency.

---
 rtl/jtframe_prog_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_jtframe_prog_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_prog_fifo.sv
// jtframe_prog_fifo: write buffer between the download formatter and the SDRAM
// programming port. Byte-lane writes are optionally merged into full words and
// queued in a small FIFO that is replayed to the SDRAM with a req/ack handshake.
//
// Handshakes:
//   input side  - in_we is a level held by upstream until in_ack; in_ack is a
//                 one-cycle pulse after the capturing edge, and nothing is
//                 captured while in_ack is high.
//   SDRAM side  - sd_we is held with sd_addr/sd_data/sd_mask stable until
//                 sd_ack is seen; sd_we then drops for exactly one cycle.
//                 sd_ack is ignored while sd_we is low.
//
// Optional feature: define JTFRAME_PROG_MERGE_EN to enable the merge register
// that pairs complementary byte lanes to the same address into one write.
module jtframe_prog_fifo #(
    parameter int AW         = 22,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] in_addr,
    input  logic [15:0]   in_data,
    input  logic [1:0]    in_mask,
    input  logic          in_we,
    output logic          in_ack,
    output logic [AW-1:0] sd_addr,
    output logic [15:0]   sd_data,
    output logic [1:0]    sd_mask,
    output logic          sd_we,
    input  logic          sd_ack,
    output logic          busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = AW + 18;   // entry = {addr, data, mask}
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] PTR_TWO = (DEPTH_LOG2+1)'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [EW-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr1;
    logic                full, empty, slot_ok, cap, noop, pop, load_out, dl_q;
    logic [1:0]          push_cnt;
    logic [EW-1:0]       in_ent, push_a, push_b, head;

    assign in_ent  = {in_addr, in_data, in_mask};
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign wr_ptr1 = wr_ptr + PTR_ONE;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign noop    = (in_mask == 2'b11);
    assign cap     = in_we && !in_ack && slot_ok;
    assign pop     = (state == S_REQ) && sd_ack;

    // Previous value of downloading, used to spot the end of the download window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dl_q <= 1'b0;
        else     dl_q <= downloading;
    end

`ifdef JTFRAME_PROG_MERGE_EN
    // A capture may push the old hold entry and the new word in one edge,
    // so two free entries are needed before accepting anything.
    localparam logic [DEPTH_LOG2:0] USED_MAX2 = (DEPTH_LOG2+1)'(DEPTH - 2);

    logic                hold_v, hold_v_nxt, flush_pend, flush_req;
    logic [EW-1:0]       hold_ent, hold_ent_nxt, merged;
    logic [DEPTH_LOG2:0] used;

    assign used      = wr_ptr - rd_ptr;
    assign slot_ok   = (used <= USED_MAX2);
    assign flush_req = flush_pend || (dl_q && !downloading);
    // Each lane comes from whichever source enables it
    assign merged    = {in_addr,
                        in_mask[1] ? hold_ent[17:10] : in_data[15:8],
                        in_mask[0] ? hold_ent[9:2]   : in_data[7:0],
                        2'b00};

    // Decide what a capture or a flush pushes and what the hold becomes
    always_comb begin
        push_cnt     = 2'd0;
        push_a       = '0;
        push_b       = '0;
        hold_v_nxt   = hold_v;
        hold_ent_nxt = hold_ent;
        if (cap && !noop) begin
            if (in_mask == 2'b00) begin
                if (hold_v) begin
                    push_cnt = 2'd2;
                    push_a   = hold_ent;
                    push_b   = in_ent;
                end else begin
                    push_cnt = 2'd1;
                    push_a   = in_ent;
                end
                hold_v_nxt = 1'b0;
            end else if (!hold_v) begin
                hold_v_nxt   = 1'b1;
                hold_ent_nxt = in_ent;
            end else if (hold_ent[EW-1:18] == in_addr && hold_ent[1:0] == ~in_mask) begin
                push_cnt   = 2'd1;
                push_a     = merged;
                hold_v_nxt = 1'b0;
            end else begin
                push_cnt     = 2'd1;
                push_a       = hold_ent;
                hold_ent_nxt = in_ent;
            end
        end else if (flush_req && hold_v && !full) begin
            push_cnt   = 2'd1;
            push_a     = hold_ent;
            hold_v_nxt = 1'b0;
        end
    end

    // Hold register and the pending-flush flag (kept until the hold is pushed)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v     <= 1'b0;
            hold_ent   <= '0;
            flush_pend <= 1'b0;
        end else begin
            hold_v     <= hold_v_nxt;
            hold_ent   <= hold_ent_nxt;
            flush_pend <= flush_req && hold_v_nxt;
        end
    end

    assign busy = hold_v || !empty || sd_we;
`else
    assign slot_ok = !full;

    // Every non-no-op capture pushes the input unchanged
    always_comb begin
        push_cnt = (cap && !noop) ? 2'd1 : 2'd0;
        push_a   = in_ent;
        push_b   = '0;
    end

    // A download write still waiting for a slot also keeps busy high
    assign busy = !empty || sd_we || (dl_q && in_we && !in_ack);
`endif

    // FIFO storage: two write ports into consecutive slots
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) mem[wr_ptr[DEPTH_LOG2-1:0]]  <= push_a;
        if (push_cnt == 2'd2) mem[wr_ptr1[DEPTH_LOG2-1:0]] <= push_b;
    end

    // FIFO pointers and the capture acknowledge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_ack <= 1'b0;
        end else begin
            if (push_cnt == 2'd2)      wr_ptr <= wr_ptr + PTR_TWO;
            else if (push_cnt == 2'd1) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            in_ack <= cap;
        end
    end

    // Output FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Output FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_REQ;
            S_REQ:   if (sd_ack) state_nxt = S_GAP;
            S_GAP:   state_nxt = empty ? S_IDLE : S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output FSM: outputs
    always_comb begin
        sd_we    = (state == S_REQ);
        load_out = (state != S_REQ) && (state_nxt == S_REQ);
    end

    // SDRAM-side registers latch the head when a request starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_addr <= '0;
            sd_data <= '0;
            sd_mask <= 2'b11;
        end else if (load_out) begin
            {sd_addr, sd_data, sd_mask} <= head;
        end
    end
endmodule

// File: tb/tb_jtframe_prog_fifo.sv
// Testbench for jtframe_prog_fifo. Works with or without JTFRAME_PROG_MERGE_EN.
`timescale 1ns/1ps
module tb_jtframe_prog_fifo;
    localparam int AW         = 22;
    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int EW         = AW + 18;
`ifdef JTFRAME_PROG_MERGE_EN
    localparam int PAIR_WRITES = 1;          // complementary lanes become one write
    localparam int BP_ACCEPT   = DEPTH - 1;  // full words need two free entries
`else
    localparam int PAIR_WRITES = 2;
    localparam int BP_ACCEPT   = DEPTH;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [15:0]   in_data = '0;
    logic [1:0]    in_mask = 2'b11;
    logic          in_we = 1'b0;
    logic          in_ack;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_data;
    logic [1:0]    sd_mask;
    logic          sd_we;
    logic          sd_ack = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    jtframe_prog_fifo #(.AW(AW), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
        .in_we(in_we), .in_ack(in_ack),
        .sd_addr(sd_addr), .sd_data(sd_data), .sd_mask(sd_mask),
        .sd_we(sd_we), .sd_ack(sd_ack), .busy(busy)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    int accepted = 0;
    int writes_seen = 0;

    // reference model of the merge register
    logic          mh_v = 1'b0;
    logic [AW-1:0] mh_addr = '0;
    logic [15:0]   mh_data = '0;
    logic [1:0]    mh_mask = 2'b11;

    // SDRAM responder knobs
    bit ack_en = 1'b1;
    int ack_delay = 0;
    bit spurious = 1'b0;
    bit gap_check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        exp_q.push_back({a, d, m});
    endtask

    // Expected SDRAM writes produced by one accepted input write
    task automatic model_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        logic [15:0] md;
        if (m == 2'b11) return;
`ifdef JTFRAME_PROG_MERGE_EN
        if (m == 2'b00) begin
            if (mh_v) push_exp(mh_addr, mh_data, mh_mask);
            push_exp(a, d, m);
            mh_v = 1'b0;
        end else if (!mh_v) begin
            mh_v = 1'b1; mh_addr = a; mh_data = d; mh_mask = m;
        end else if (mh_addr == a && (mh_mask ^ m) == 2'b11) begin
            md[7:0]  = (m[0] == 1'b0) ? d[7:0]  : mh_data[7:0];
            md[15:8] = (m[1] == 1'b0) ? d[15:8] : mh_data[15:8];
            push_exp(a, md, 2'b00);
            mh_v = 1'b0;
        end else begin
            push_exp(mh_addr, mh_data, mh_mask);
            mh_addr = a; mh_data = d; mh_mask = m;
        end
`else
        md = d;
        push_exp(a, md, m);
`endif
    endtask

    task automatic model_flush();
        if (mh_v) push_exp(mh_addr, mh_data, mh_mask);
        mh_v = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        int n;
        n = 0;
        in_addr = a; in_data = d; in_mask = m; in_we = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!in_ack && n < 300);
        in_we = 1'b0;
        if (!in_ack) begin
            total++; bad++;
            $display("FAIL send_timeout: addr %0h got no in_ack in %0d cycles, want an ack", a, n);
        end else begin
            accepted++;
            model_write(a, d, m);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sd_we || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    // ---------------- monitor / SDRAM responder ----------------
    bit            in_req = 1'b0;
    int            wait_cnt = 0;
    int            gap_len = 0;
    logic [EW-1:0] cur = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_req = 1'b0;
            sd_ack = 1'b0;
            wait_cnt = 0;
        end else if (sd_we) begin
            if (!in_req) begin
                in_req = 1'b1;
                wait_cnt = 0;
                writes_seen++;
                cur = {sd_addr, sd_data, sd_mask};
                if (gap_check_en) check("gap_len", gap_len, 1);
                gap_len = 0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got %0h, want no write", cur);
                end else begin
                    check("sd_write", cur, exp_q.pop_front());
                end
            end else begin
                check("sd_stable", {sd_addr, sd_data, sd_mask}, cur);
            end
            sd_ack = ack_en && (wait_cnt >= ack_delay);
            wait_cnt++;
        end else begin
            in_req = 1'b0;
            gap_len++;
            sd_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int w0;
        // reset held with a request pending
        downloading = 1'b1;
        in_addr = 22'h5; in_data = 16'h1234; in_mask = 2'b00; in_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_in_ack", in_ack, 1'b0);
            check("rst_sd_we", sd_we, 1'b0);
            check("rst_sd_mask", sd_mask, 2'b11);
            check("rst_busy", busy, 1'b0);
        end
        check("rst_sd_addr", sd_addr, 0);
        check("rst_sd_data", sd_data, 0);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!in_ack && n < 10);
        check("first_capture_cycles", (n <= 2), 1'b1);
        if (in_ack) begin
            accepted++;
            model_write(in_addr, in_data, in_mask);
        end
        in_we = 1'b0;
        @(posedge clk); #1;
        check("sd_we_latency", sd_we, 1'b1);
        wait_drain("first");

        // merge pair
        w0 = writes_seen;
        send(22'h10, 16'h00AB, 2'b10);
        send(22'h10, 16'hCD00, 2'b01);
        wait_drain("pair");
        check("pair_writes", writes_seen - w0, PAIR_WRITES);

        // non-matching partials, flushed by the end of download
        w0 = writes_seen;
        send(22'h10, 16'h0011, 2'b10);
        send(22'h11, 16'h0022, 2'b10);
        repeat (3) @(posedge clk);
        #1 downloading = 1'b0;
        model_flush();
        wait_drain("flush");
        check("flush_writes", writes_seen - w0, 2);
        downloading = 1'b1;

        // back-pressure: SDRAM stalls, then drains
        w0 = writes_seen;
        n = accepted;
        ack_en = 1'b0;
        ack_delay = 0;
        fork
            for (int i = 0; i < 20; i++) send(22'h100 + 22'(i), 16'($urandom), 2'b00);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("bp_accepted", accepted - n, BP_ACCEPT);
                gap_check_en = 1'b1;
                ack_en = 1'b1;
            end
        join
        wait_drain("bp");
        gap_check_en = 1'b0;
        check("bp_writes", writes_seen - w0, 20);

        // pointer wrap with delayed acks
        w0 = writes_seen;
        ack_delay = 3;
        for (int i = 0; i < 3 * DEPTH; i++) send(22'h200 + 22'(i), 16'($urandom), 2'b00);
        wait_drain("wrap");
        check("wrap_writes", writes_seen - w0, 3 * DEPTH);

        // random lanes, addresses and ack timing, with acks while idle
        spurious = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) ack_delay = $urandom_range(0, 4);
            send(22'h300 + 22'($urandom_range(0, 3)), 16'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        @(posedge clk); #1;
        downloading = 1'b0;
        model_flush();
        wait_drain("random");
        downloading = 1'b1;
        spurious = 1'b0;
        ack_delay = 0;

        // reset in the middle of a stalled queue drops everything
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) send(22'h400 + 22'(i), 16'($urandom), 2'b00);
        send(22'h410, 16'h00EE, 2'b10);
        w0 = writes_seen;
        rst = 1'b1;
        exp_q.delete();
        mh_v = 1'b0;
        #1;
        check("midrst_sd_we", sd_we, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_sd_mask", sd_mask, 2'b11);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ack_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_writes", writes_seen - w0, 0);
        check("midrst_busy_after", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
